reg_wb_queue: RTL and testbench

Write-back queue feeding the register file's single write port (WE3/AD3/WD3). Collects completed results from two producers, the ALU and the load unit, and buffers them in program order in a small circular FIFO. It drains one entry per cycle into the register file and exposes a forwarding lookup, so decode sees pending, not-yet-written values.

---
 rtl/reg_wb_queue_if.sv | 46 ++++
 rtl/reg_wb_queue.sv | 113 +++++++++++
 tb/tb_reg_wb_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_queue_if.sv
// rtl/reg_wb_queue_if.sv - producer, register-file write and forwarding bus of the write-back queue
//
// Signals:
//   alu_valid/alu_rd/alu_data/alu_ready : ALU result handshake (ready from the queue)
//   ld_valid/ld_rd/ld_data/ld_ready     : load result handshake (ready from the queue)
//   WE3/AD3/WD3                         : register-file write port, driven by the queue
//   AD1/AD2                             : decode read addresses used for the forwarding lookup
//   fwd_hit1/2, fwd_data1/2             : youngest pending queued value for AD1/AD2
//   count                               : current queue occupancy
// Modports: master = producers/decode/register-file side, slave = the queue itself.
interface reg_wb_queue_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     alu_valid;
  logic [ADDRESS_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     alu_ready;
  logic                     ld_valid;
  logic [ADDRESS_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_ready;
  logic                     WE3;
  logic [ADDRESS_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0]    WD3;
  logic [ADDRESS_WIDTH-1:0] AD1;
  logic [ADDRESS_WIDTH-1:0] AD2;
  logic                     fwd_hit1;
  logic                     fwd_hit2;
  logic [DATA_WIDTH-1:0]    fwd_data1;
  logic [DATA_WIDTH-1:0]    fwd_data2;
  logic [CNT_W-1:0]         count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, AD1, AD2,
    input  alu_ready, ld_ready, WE3, AD3, WD3, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, AD1, AD2,
    output alu_ready, ld_ready, WE3, AD3, WD3, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order write-back queue in front of the register-file write port
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, discards every queued entry
//   q   : reg_wb_queue_if.slave - ALU/load producer handshakes, WE3/AD3/WD3 drain,
//         AD1/AD2 forwarding lookup with fwd_hit/fwd_data, and occupancy count
module reg_wb_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     pop;
  logic [CNT_W-1:0]         free;
  logic                     alu_ready;
  logic                     ld_ready;
  logic                     alu_takes;
  logic                     ld_takes;
  logic [PTR_W-1:0]         ld_slot;

  // Queue control: acceptance, enqueue into the entry array, pointer/count update.
  always_comb begin
    pop  = (count_q != '0);
    // The head always pops when non-empty, so that slot is reusable this same edge.
    free = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

    alu_ready = (free >= CNT_W'(1));
    alu_takes = q.alu_valid & alu_ready & (q.alu_rd != '0);
    // Ready of the load looks only at count and the ALU request, never at ld_*.
    ld_ready  = (free >= (alu_takes ? CNT_W'(2) : CNT_W'(1)));
    ld_takes  = q.ld_valid & ld_ready & (q.ld_rd != '0);

    rd_d   = rd_q;
    data_d = data_q;
    // The load is younger than a same-cycle ALU result, so it lands one slot later.
    ld_slot = tail_q + PTR_W'(alu_takes);
    if (alu_takes) begin
      rd_d[tail_q]   = q.alu_rd;
      data_d[tail_q] = q.alu_data;
    end
    if (ld_takes) begin
      rd_d[ld_slot]   = q.ld_rd;
      data_d[ld_slot] = q.ld_data;
    end

    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(alu_takes) + PTR_W'(ld_takes);
    count_d = count_q + CNT_W'(alu_takes) + CNT_W'(ld_takes) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    // Entry payloads need no reset: nothing outside [head, head+count) is ever observed.
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  // Drain and forwarding, from registered state only.
  logic [PTR_W-1:0] idx;

  always_comb begin
    q.alu_ready = alu_ready;
    q.ld_ready  = ld_ready;
    q.count     = count_q;
    q.WE3       = pop;
    q.AD3       = pop ? rd_q[head_q]   : '0;
    q.WD3       = pop ? data_q[head_q] : '0;

    q.fwd_hit1  = 1'b0;
    q.fwd_hit2  = 1'b0;
    q.fwd_data1 = '0;
    q.fwd_data2 = '0;
    idx         = head_q;
    // Walk from oldest to youngest so the last match wins; the head being
    // drained this cycle is still a valid forwarding source.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((q.AD1 != '0) && (rd_q[idx] == q.AD1)) begin
          q.fwd_hit1  = 1'b1;
          q.fwd_data1 = data_q[idx];
        end
        if ((q.AD2 != '0) && (rd_q[idx] == q.AD2)) begin
          q.fwd_hit2  = 1'b1;
          q.fwd_data2 = data_q[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - randomized self-checking bench for reg_wb_queue
module tb_reg_wb_queue;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  reg_wb_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];      // model of pending writes, oldest first
  ent_t sb_exp[$];  // every write the model says was accepted
  ent_t sb_obs[$];  // every write the DUT drove on WE3

  logic          exp_we, exp_hit1, exp_hit2, exp_alu_ready, exp_ld_ready;
  logic [AW-1:0] exp_ad3;
  logic [DW-1:0] exp_wd3, exp_d1, exp_d2;
  logic [CW-1:0] exp_count;
  bit            m_alu_take, m_ld_take, m_ld_consumed;
  ent_t          m_alu_ent, m_ld_ent;

  // Expected outputs for the current cycle from the pending list and current inputs.
  function automatic void model_eval();
    int n    = mq.size();
    int free = DEPTH - n + ((n != 0) ? 1 : 0);
    exp_we    = (n != 0);
    exp_ad3   = (n != 0) ? mq[0].rd : '0;
    exp_wd3   = (n != 0) ? mq[0].data : '0;
    exp_count = CW'(n);
    exp_hit1 = 1'b0; exp_d1 = '0;
    exp_hit2 = 1'b0; exp_d2 = '0;
    foreach (mq[i]) begin
      if (bus.AD1 != 0 && mq[i].rd == bus.AD1) begin exp_hit1 = 1'b1; exp_d1 = mq[i].data; end
      if (bus.AD2 != 0 && mq[i].rd == bus.AD2) begin exp_hit2 = 1'b1; exp_d2 = mq[i].data; end
    end
    exp_alu_ready = (free >= 1);
    m_alu_take    = bus.alu_valid && exp_alu_ready && (bus.alu_rd != 0);
    exp_ld_ready  = (free >= (m_alu_take ? 2 : 1));
    m_ld_consumed = bus.ld_valid && exp_ld_ready;
    m_ld_take     = m_ld_consumed && (bus.ld_rd != 0);
    m_alu_ent.rd = bus.alu_rd; m_alu_ent.data = bus.alu_data;
    m_ld_ent.rd  = bus.ld_rd;  m_ld_ent.data  = bus.ld_data;
  endfunction

  function automatic void model_clock(bit r);
    if (r) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (m_alu_take) begin mq.push_back(m_alu_ent); sb_exp.push_back(m_alu_ent); end
      if (m_ld_take)  begin mq.push_back(m_ld_ent);  sb_exp.push_back(m_ld_ent);  end
    end
  endfunction

  task automatic drive(input bit r, input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(negedge clk);
    rst = r;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ldat;
    bus.AD1 = a1; bus.AD2 = a2;
    #1;
    model_eval();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_clock(rst);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", bus.WE3); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if ({bus.alu_ready, bus.ld_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b%b want 11", bus.alu_ready, bus.ld_ready); end
    checks++; if ({bus.fwd_hit1, bus.fwd_hit2} !== 2'b00 || bus.fwd_data1 !== '0) begin errors++; $display("FAIL reset_fwd: got hit %b%b data %h want 00/0", bus.fwd_hit1, bus.fwd_hit2, bus.fwd_data1); end
    checks++; if (bus.AD3 !== '0 || bus.WD3 !== '0) begin errors++; $display("FAIL reset_ad3_wd3: got %0d/%h want 0/0", bus.AD3, bus.WD3); end
    clock_edge();
  endtask

  task automatic test_single_alu();
    drive(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 5'd5, 0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    checks++; if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin errors++; $display("FAIL single_drain: got we %b ad %0d wd %h want 1/5/deadbeef", bus.WE3, bus.AD3, bus.WD3); end
    checks++; if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_fwd: got %b/%h want 1/deadbeef", bus.fwd_hit1, bus.fwd_data1); end
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    checks++; if (bus.count !== '0 || bus.WE3 !== 1'b0) begin errors++; $display("FAIL single_empty: got count %0d we %b want 0/0", bus.count, bus.WE3); end
    clock_edge();
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 5'd7, 5'd7);
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL pair_ld_ready: got %b want 1", bus.ld_ready); end
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    checks++; if (bus.count !== CW'(2) || bus.WD3 !== 32'h11) begin errors++; $display("FAIL pair_first: got count %0d wd %h want 2/11", bus.count, bus.WD3); end
    checks++; if ({bus.fwd_hit1, bus.fwd_hit2} !== 2'b11 || bus.fwd_data1 !== 32'h22 || bus.fwd_data2 !== 32'h22) begin errors++; $display("FAIL pair_youngest: got %b%b %h %h want 11 22 22", bus.fwd_hit1, bus.fwd_hit2, bus.fwd_data1, bus.fwd_data2); end
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checks++; if ({bus.WE3, bus.AD3, bus.WD3} !== {1'b1, 5'd7, 32'h22}) begin errors++; $display("FAIL pair_second: got %b %0d %h want 1 7 22", bus.WE3, bus.AD3, bus.WD3); end
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL pair_done: got we %b want 0", bus.WE3); end
    clock_edge();
  endtask

  task automatic test_x0();
    drive(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_ready !== 1'b1 || bus.fwd_hit1 !== 1'b0) begin errors++; $display("FAIL x0_accept: got ready %b hit %b want 1/0", bus.alu_ready, bus.fwd_hit1); end
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.count !== '0 || bus.WE3 !== 1'b0 || bus.fwd_hit1 !== 1'b0) begin errors++; $display("FAIL x0_idle: got count %0d we %b hit %b want 0/0/0", bus.count, bus.WE3, bus.fwd_hit1); end
      clock_edge();
    end
  endtask

  task automatic test_backpressure();
    bit            saw_full = 0, saw_ld_block = 0, hold_ld = 0;
    logic [AW-1:0] lrd = 0;
    logic [DW-1:0] ldat = 0;
    int            cyc = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    sb_exp.delete();
    sb_obs.delete();
    while (sb_exp.size() < 50 && cyc < 400) begin
      if (!hold_ld) begin
        lrd  = AW'($urandom_range(1, 7));
        ldat = $urandom;
      end
      drive(0, 1, AW'($urandom_range(($urandom_range(0, 9) == 0) ? 0 : 1, 7)), $urandom,
            1, lrd, ldat, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      checks++;
      if ({bus.WE3, bus.AD3, bus.WD3, bus.count, bus.alu_ready, bus.ld_ready,
           bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2} !==
          {exp_we, exp_ad3, exp_wd3, exp_count, exp_alu_ready, exp_ld_ready,
           exp_hit1, exp_d1, exp_hit2, exp_d2}) begin
        errors++;
        $display("FAIL bp_outputs cyc %0d: got we%b ad%0d wd%h cnt%0d rdy%b%b h1%b d1%h h2%b d2%h want we%b ad%0d wd%h cnt%0d rdy%b%b h1%b d1%h h2%b d2%h",
                 cyc, bus.WE3, bus.AD3, bus.WD3, bus.count, bus.alu_ready, bus.ld_ready, bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2,
                 exp_we, exp_ad3, exp_wd3, exp_count, exp_alu_ready, exp_ld_ready, exp_hit1, exp_d1, exp_hit2, exp_d2);
      end
      if (bus.count == CW'(DEPTH)) saw_full = 1;
      if (m_alu_take && !bus.ld_ready) saw_ld_block = 1;
      if (bus.WE3) sb_obs.push_back({bus.AD3, bus.WD3});
      hold_ld = !m_ld_consumed;
      clock_edge();
      cyc++;
    end
    checks++; if (sb_exp.size() < 50) begin errors++; $display("FAIL bp_budget: got %0d writes want 50", sb_exp.size()); end
    cyc = 0;
    while (mq.size() != 0 && cyc < 20) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (bus.WE3) sb_obs.push_back({bus.AD3, bus.WD3});
      clock_edge();
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.WE3 !== 1'b0 || bus.count !== '0) begin errors++; $display("FAIL bp_drained: got we %b count %0d want 0/0", bus.WE3, bus.count); end
    checks++; if (saw_full !== 1'b1 || saw_ld_block !== 1'b1) begin errors++; $display("FAIL bp_saturate: got full %b ld_block %b want 1/1", saw_full, saw_ld_block); end
    checks++; if (sb_obs.size() != sb_exp.size()) begin errors++; $display("FAIL bp_sb_count: got %0d writes want %0d", sb_obs.size(), sb_exp.size()); end
    for (int i = 0; i < sb_exp.size() && i < sb_obs.size(); i++) begin
      checks++;
      if (sb_obs[i] !== sb_exp[i]) begin errors++; $display("FAIL bp_sb_entry %0d: got %0d/%h want %0d/%h", i, sb_obs[i].rd, sb_obs[i].data, sb_exp[i].rd, sb_exp[i].data); end
    end
    clock_edge();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 5'd9, 32'hA1, 1, 5'd10, 32'hA2, 0, 0);
    clock_edge();
    drive(0, 1, 5'd11, 32'hA3, 1, 5'd12, 32'hA4, 0, 0);
    clock_edge();
    drive(1, 1, 5'd13, 32'hA5, 1, 5'd14, 32'hA6, 0, 0);
    checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL rmid_filled: got count %0d want 3", bus.count); end
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, AW'(10 + i), 5'd13);
      checks++; if (bus.WE3 !== 1'b0 || bus.count !== '0 || bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin errors++; $display("FAIL rmid_stale %0d: got we %b count %0d hit %b%b want 0/0/00", i, bus.WE3, bus.count, bus.fwd_hit1, bus.fwd_hit2); end
      clock_edge();
    end
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
    bus.AD1 = 0; bus.AD2 = 0;
    test_reset();
    test_single_alu();
    test_same_cycle();
    test_x0();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
